// File: rtl/spiflash_responder_if.sv
// SPI pin and byte-memory port bundle for spiflash_responder.
// master: SPI host plus memory; slave: the responder.
interface spiflash_responder_if #(
    parameter int ADDR_W = 24
);
    logic              spiflash_cs_n;
    logic              spiflash_clk;
    logic              spiflash_mosi;
    logic              spiflash_miso;
    logic              spiflash_miso_oe;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              underrun;

    modport master (
        output spiflash_cs_n,
        output spiflash_clk,
        output spiflash_mosi,
        output mem_ack,
        output mem_rdata,
        input  spiflash_miso,
        input  spiflash_miso_oe,
        input  mem_req,
        input  mem_addr,
        input  underrun
    );

    modport slave (
        input  spiflash_cs_n,
        input  spiflash_clk,
        input  spiflash_mosi,
        input  mem_ack,
        input  mem_rdata,
        output spiflash_miso,
        output spiflash_miso_oe,
        output mem_req,
        output mem_addr,
        output underrun
    );
endinterface

// File: rtl/spiflash_responder.sv
// SPI flash responder (mode 0): READ 0x03, JEDEC ID 0x9F, 0xAB ignored.
// Oversampled SPI pins, byte memory port with one-deep prefetch.
module spiflash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    spiflash_responder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ID,
        S_IGNORE
    } state_t;

    logic [1:0]        cs_sync;
    logic [1:0]        sck_sync;
    logic [1:0]        mosi_sync;
    logic              sck_prev;
    logic              cs_n_q;
    logic              sck_q;
    logic              mosi_q;
    logic              sck_rise;
    logic              sck_fall;

    state_t            state;
    logic [4:0]        bit_cnt;
    logic [6:0]        cmd_sr;
    logic [22:0]       addr_sr;
    logic [7:0]        out_sr;
    logic [1:0]        id_idx;
    logic [7:0]        hold_data;
    logic              hold_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic              discard;

    logic              miso_r;
    logic              miso_oe_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              underrun_r;

    logic [7:0]        cmd_byte;
    logic [23:0]       addr_word;
    logic [7:0]        load_byte;
    logic [7:0]        id_next;
    logic              ack_ok;
    logic              fetch_go;

    assign cs_n_q   = cs_sync[1];
    assign sck_q    = sck_sync[1];
    assign mosi_q   = mosi_sync[1];
    assign sck_rise = sck_q & ~sck_prev;
    assign sck_fall = ~sck_q & sck_prev;

    assign bus.spiflash_miso    = miso_r;
    assign bus.spiflash_miso_oe = miso_oe_r;
    assign bus.mem_req          = mem_req_r;
    assign bus.mem_addr         = mem_addr_r;
    assign bus.underrun         = underrun_r;

    // Bring the asynchronous SPI pins into sys_clk; remember last SCK level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cs_sync   <= 2'b11;
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            sck_prev  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], bus.spiflash_cs_n};
            sck_sync  <= {sck_sync[0], bus.spiflash_clk};
            mosi_sync <= {mosi_sync[0], bus.spiflash_mosi};
            sck_prev  <= sck_q;
        end
    end

    // Next-byte selection, ID byte mux and fetch permission.
    always_comb begin
        cmd_byte  = {cmd_sr, mosi_q};
        addr_word = {addr_sr, mosi_q};
        load_byte = hold_valid ? hold_data : 8'hFF;
        ack_ok    = bus.mem_ack & mem_req_r;
        fetch_go  = (state == S_DATA) & ~cs_n_q
                  & ~mem_req_r & ~hold_valid;
        case (id_idx)
            2'd1:    id_next = JEDEC_ID[15:8];
            2'd2:    id_next = JEDEC_ID[7:0];
            default: id_next = 8'h00;
        endcase
    end

    // Command FSM, MISO shifter and memory request/prefetch engine.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            addr_sr    <= '0;
            out_sr     <= '0;
            id_idx     <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            fetch_addr <= '0;
            discard    <= 1'b0;
            miso_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= '0;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            if (cs_n_q) begin
                state      <= S_IDLE;
                bit_cnt    <= '0;
                miso_r     <= 1'b0;
                miso_oe_r  <= 1'b0;
                hold_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_CMD;
                        bit_cnt <= '0;
                    end
                    S_CMD: if (sck_rise) begin
                        cmd_sr  <= cmd_byte[6:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            case (cmd_byte)
                                8'h03: state <= S_ADDR;
                                8'h9F: begin
                                    state  <= S_ID;
                                    out_sr <= JEDEC_ID[23:16];
                                    id_idx <= 2'd1;
                                end
                                default: state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR: if (sck_rise) begin
                        addr_sr <= addr_word[22:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt    <= '0;
                            state      <= S_DATA;
                            fetch_addr <= addr_word[ADDR_W-1:0];
                            // A discarded request may still be pending;
                            // the fetch then issues after its ack.
                            if (!mem_req_r) begin
                                mem_req_r  <= 1'b1;
                                mem_addr_r <= addr_word[ADDR_W-1:0];
                            end
                        end
                    end
                    S_DATA: begin
                        if (fetch_go) begin
                            mem_req_r  <= 1'b1;
                            mem_addr_r <= fetch_addr;
                        end
                        if (sck_fall) begin
                            miso_oe_r <= 1'b1;
                            bit_cnt   <= {2'b00, bit_cnt[2:0] + 3'd1};
                            if (bit_cnt[2:0] == 3'd0) begin
                                miso_r     <= load_byte[7];
                                out_sr     <= {load_byte[6:0], 1'b0};
                                underrun_r <= ~hold_valid;
                                hold_valid <= 1'b0;
                            end else begin
                                miso_r <= out_sr[7];
                                out_sr <= {out_sr[6:0], 1'b0};
                            end
                        end
                    end
                    S_ID: if (sck_fall) begin
                        miso_oe_r <= 1'b1;
                        miso_r    <= out_sr[7];
                        bit_cnt   <= {2'b00, bit_cnt[2:0] + 3'd1};
                        if (bit_cnt[2:0] == 3'd7) begin
                            out_sr <= id_next;
                            if (id_idx != 2'd3) begin
                                id_idx <= id_idx + 2'd1;
                            end
                        end else begin
                            out_sr <= {out_sr[6:0], 1'b0};
                        end
                    end
                    S_IGNORE: begin
                        miso_r    <= 1'b0;
                        miso_oe_r <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
            // An ack always retires the request; its data is kept only
            // for a live read that did not abandon it.
            if (ack_ok) begin
                mem_req_r <= 1'b0;
                discard   <= 1'b0;
                if (!discard && !cs_n_q && state == S_DATA) begin
                    hold_data  <= bus.mem_rdata;
                    hold_valid <= 1'b1;
                    fetch_addr <= fetch_addr + ADDR_W'(1);
                end
            end else if (cs_n_q && mem_req_r) begin
                discard <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spiflash_responder.sv
// Directed bench for spiflash_responder: READ, JEDEC ID, ignored
// command, address wrap, underrun, aborted address and reset.
module tb_spiflash_responder;
    localparam int HP = 6;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    always #5 sys_clk = ~sys_clk;

    spiflash_responder_if #(.ADDR_W(24)) bus ();

    spiflash_responder #(
        .ADDR_W  (24),
        .JEDEC_ID(24'hEF4018)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          ack_lat = 3;
    int          under_cnt = 0;
    logic        req_seen = 1'b0;
    logic        oe_seen = 1'b0;
    logic [23:0] req_log [$];
    logic [7:0]  rxb [8];

    // Memory model: data = addr[7:0] ^ 0xA5 after ack_lat cycles.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge sys_clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                req_log.push_back(bus.mem_addr);
                repeat (ack_lat - 1) @(negedge sys_clk);
                bus.mem_rdata = bus.mem_addr[7:0] ^ 8'hA5;
                bus.mem_ack   = 1'b1;
            end
        end
    end

    // Sticky observers of request, output enable and underrun pulses.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (bus.mem_req) req_seen = 1'b1;
            if (bus.spiflash_miso_oe) oe_seen = 1'b1;
            if (bus.underrun) under_cnt++;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        bus.spiflash_clk  = 1'b0;
        bus.spiflash_mosi = b;
        cyc(HP);
        bus.spiflash_clk = 1'b1;
        r = bus.spiflash_miso;
        cyc(HP);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_start();
        bus.spiflash_cs_n = 1'b0;
        cyc(HP);
    endtask

    task automatic cs_stop();
        bus.spiflash_cs_n = 1'b1;
        cyc(HP);
        bus.spiflash_clk = 1'b0;
        cyc(2 * HP);
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [7:0] d;
        cs_start();
        spi_byte(8'h03, d);
        spi_byte(a[23:16], d);
        spi_byte(a[15:8], d);
        spi_byte(a[7:0], d);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, d);
            rxb[i] = d;
        end
        cs_stop();
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return {8'h00, req_log[i]};
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        logic [7:0] d;
        logic       r;
        bus.spiflash_cs_n = 1'b1;
        bus.spiflash_clk  = 1'b0;
        bus.spiflash_mosi = 1'b0;
        cyc(3);
        check("rst_miso", bus.spiflash_miso, 0);
        check("rst_oe", bus.spiflash_miso_oe, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_under", bus.underrun, 0);
        sys_rst = 1'b0;
        cyc(5);

        // READ 0x000010, 4 bytes, 3-cycle memory
        req_log.delete();
        under_cnt = 0;
        do_read(24'h000010, 4);
        cyc(10);
        check("rd_b0", rxb[0], 32'hB5);
        check("rd_b1", rxb[1], 32'hB4);
        check("rd_b2", rxb[2], 32'hB7);
        check("rd_b3", rxb[3], 32'hB6);
        check("rd_nreq", req_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rd_addr%0d", i), log_at(i), 32'h10 + i);
        end
        check("rd_under", under_cnt, 0);

        // JEDEC ID
        req_seen = 1'b0;
        cs_start();
        spi_byte(8'h9F, d);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, d);
            rxb[i] = d;
        end
        check("id_oe", bus.spiflash_miso_oe, 1);
        cs_stop();
        check("id_b0", rxb[0], 32'hEF);
        check("id_b1", rxb[1], 32'h40);
        check("id_b2", rxb[2], 32'h18);
        check("id_b3", rxb[3], 32'h00);
        check("id_noreq", req_seen, 0);

        // Unknown command 0x5A, then a normal read at 0
        req_seen = 1'b0;
        oe_seen  = 1'b0;
        cs_start();
        spi_byte(8'h5A, d);
        spi_byte(8'h00, d);
        spi_byte(8'h00, d);
        cs_stop();
        check("ign_oe", oe_seen, 0);
        check("ign_req", req_seen, 0);
        do_read(24'h000000, 2);
        check("ign_rd0", rxb[0], 32'hA5);
        check("ign_rd1", rxb[1], 32'hA4);

        // Address wrap
        req_log.delete();
        do_read(24'hFFFFFE, 3);
        cyc(10);
        check("wr_b0", rxb[0], 32'h5B);
        check("wr_b1", rxb[1], 32'h5A);
        check("wr_b2", rxb[2], 32'hA5);
        check("wr_a0", log_at(0), 32'hFFFFFE);
        check("wr_a1", log_at(1), 32'hFFFFFF);
        check("wr_a2", log_at(2), 32'h000000);

        // Underrun: 40-cycle memory
        ack_lat   = 40;
        under_cnt = 0;
        do_read(24'h000100, 2);
        cyc(60);
        check("un_b0", rxb[0], 32'hFF);
        check("un_b1", rxb[1], 32'hA5);
        check("un_cnt", under_cnt, 1);
        ack_lat = 3;
        cyc(10);

        // CS raised after 13 address bits
        req_seen = 1'b0;
        cs_start();
        spi_byte(8'h03, d);
        for (int i = 0; i < 13; i++) spi_bit(1'b0, r);
        cs_stop();
        check("ab_noreq", req_seen, 0);
        do_read(24'h000020, 2);
        check("ab_rd0", rxb[0], 32'h85);
        check("ab_rd1", rxb[1], 32'h84);

        // Reset in the middle of DATA with a request outstanding
        ack_lat = 40;
        cs_start();
        spi_byte(8'h03, d);
        spi_byte(8'h00, d);
        spi_byte(8'h00, d);
        spi_byte(8'h30, d);
        spi_bit(1'b0, r);
        spi_bit(1'b0, r);
        check("mr_req_pre", bus.mem_req, 1);
        check("mr_oe_pre", bus.spiflash_miso_oe, 1);
        sys_rst = 1'b1;
        cyc(1);
        check("mr_miso", bus.spiflash_miso, 0);
        check("mr_oe", bus.spiflash_miso_oe, 0);
        check("mr_req", bus.mem_req, 0);
        check("mr_addr", bus.mem_addr, 0);
        check("mr_under", bus.underrun, 0);
        sys_rst = 1'b0;
        cs_stop();
        cyc(60);
        ack_lat = 3;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
